// File: rtl/spi_master.sv
// SPI mode-0 master for a single slave: one byte per tx handshake, MSB first,
// with SSEL held low across bytes until the producer flags the last one.
module spi_master #(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] div_cnt, div_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       tx_sr, tx_sr_n;
  logic [7:0]       rx_sr, rx_sr_n;
  logic             last_r, last_n;
  logic             sck_r, sck_n;
  logic             ssel_r, ssel_n;
  logic             mosi_r, mosi_n;
  logic             ready_r, ready_n;
  logic             busy_r, busy_n;
  logic [7:0]       rxd_r, rxd_n;
  logic             rxv_r, rxv_n;
  logic             accept;
  logic             div_end;

  assign tx_ready = ready_r;
  assign rx_data  = rxd_r;
  assign rx_valid = rxv_r;
  assign busy     = busy_r;
  assign SCK      = sck_r;
  assign SSEL     = ssel_r;
  assign MOSI     = mosi_r;

  assign accept  = tx_valid && ready_r;
  assign div_end = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      last_r  <= 1'b0;
      sck_r   <= 1'b0;
      ssel_r  <= 1'b1;
      mosi_r  <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      rxd_r   <= '0;
      rxv_r   <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_cnt_n;
      bit_cnt <= bit_cnt_n;
      tx_sr   <= tx_sr_n;
      rx_sr   <= rx_sr_n;
      last_r  <= last_n;
      sck_r   <= sck_n;
      ssel_r  <= ssel_n;
      mosi_r  <= mosi_n;
      ready_r <= ready_n;
      busy_r  <= busy_n;
      rxd_r   <= rxd_n;
      rxv_r   <= rxv_n;
    end
  end

  // Outputs are registered from the next-state decision, so every pin change
  // lands on the same clk edge as the corresponding state transition.
  always_comb begin
    state_n   = state;
    div_cnt_n = div_cnt;
    bit_cnt_n = bit_cnt;
    tx_sr_n   = tx_sr;
    rx_sr_n   = rx_sr;
    last_n    = last_r;
    sck_n     = sck_r;
    ssel_n    = ssel_r;
    mosi_n    = mosi_r;
    ready_n   = ready_r;
    busy_n    = busy_r;
    rxd_n     = rxd_r;
    rxv_n     = 1'b0;

    unique case (state)
      IDLE, HOLD: begin
        ready_n = 1'b1;
        if (accept) begin
          tx_sr_n   = tx_data;
          last_n    = tx_last;
          ssel_n    = 1'b0;
          mosi_n    = tx_data[7];
          div_cnt_n = '0;
          bit_cnt_n = '0;
          ready_n   = 1'b0;
          busy_n    = 1'b1;
          state_n   = SETUP;
        end
      end

      SETUP, LOW: begin
        if (div_end) begin
          div_cnt_n = '0;
          sck_n     = 1'b1;
          rx_sr_n   = {rx_sr[6:0], MISO};
          state_n   = HIGH;
        end else begin
          div_cnt_n = div_cnt + CNT_W'(1);
        end
      end

      // The eighth falling edge ends the byte directly: no trailing LOW dwell.
      HIGH: begin
        if (div_end) begin
          div_cnt_n = '0;
          sck_n     = 1'b0;
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
            rxd_n     = rx_sr;
            rxv_n     = 1'b1;
            if (last_r) begin
              ssel_n  = 1'b1;
              state_n = GAP;
            end else begin
              ready_n = 1'b1;
              state_n = HOLD;
            end
          end else begin
            tx_sr_n   = {tx_sr[6:0], 1'b0};
            mosi_n    = tx_sr[6];
            bit_cnt_n = bit_cnt + 3'd1;
            state_n   = LOW;
          end
        end else begin
          div_cnt_n = div_cnt + CNT_W'(1);
        end
      end

      GAP: begin
        if (div_end) begin
          div_cnt_n = '0;
          ready_n   = 1'b1;
          busy_n    = 1'b0;
          mosi_n    = 1'b0;
          state_n   = IDLE;
        end else begin
          div_cnt_n = div_cnt + CNT_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed + randomized bench for spi_master: a mode-0 slave model and
// edge-time arithmetic provide every expected value.
module tb_spi_master;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       SCK;
  logic       SSEL;
  logic       MOSI;
  logic       MISO = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // slave model / monitor state
  logic       loopback = 1'b1;
  logic [7:0] sl_tx = '0;
  logic [7:0] sl_rx = '0;
  int         sl_fall = 0;
  int         rv_cnt = 0;
  int         rv_cyc = 0;
  int         rises[$];
  int         ssel_rises[$];
  logic       sck_q = 1'b0;
  logic       ssel_q = 1'b1;

  spi_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_last(tx_last),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .SCK(SCK), .SSEL(SSEL),
    .MOSI(MOSI), .MISO(MISO)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Mode-0 slave: samples MOSI on SCK rise, advances MISO on SCK fall.
  initial forever begin
    @(negedge clk);
    if (SCK && !sck_q) begin
      rises.push_back(cyc);
      if (!SSEL) sl_rx = {sl_rx[6:0], MOSI};
    end
    if (!SCK && sck_q) sl_fall++;
    if (SSEL) sl_fall = 0;
    if (SSEL && !ssel_q) ssel_rises.push_back(cyc);
    if (rx_valid) begin
      rv_cnt++;
      rv_cyc = cyc;
    end
    MISO  = loopback ? MOSI : sl_tx[7 - (sl_fall % 8)];
    sck_q = SCK;
    ssel_q = SSEL;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, output int acc);
    int n = 0;
    while (!tx_ready && n < 40 * D) begin tick(); n++; end
    chk("ready_timeout", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    acc = cyc + 1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_rv(input int target);
    int n = 0;
    while (rv_cnt < target && n < 40 * D) begin tick(); n++; end
    chk("rv_timeout", {31'd0, rv_cnt >= target}, 32'd1);
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (rises.size() < target && n < 40 * D) begin tick(); n++; end
    chk("rise_timeout", {31'd0, rises.size() >= target}, 32'd1);
  endtask

  task automatic wait_ready(output int at);
    int n = 0;
    while (!tx_ready && n < 40 * D) begin tick(); n++; end
    chk("ready_wait_timeout", {31'd0, tx_ready}, 32'd1);
    at = cyc;
  endtask

  initial begin
    int a, a2, rv0, sr0, t_rdy;
    logic [7:0] b, s;

    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
    repeat (3) tick();
    chk("rst_sck", {31'd0, SCK}, 32'd0);
    chk("rst_ssel", {31'd0, SSEL}, 32'd1);
    chk("rst_mosi", {31'd0, MOSI}, 32'd0);
    chk("rst_rxv", {31'd0, rx_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rxdata", {24'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    chk("rdy_before_clk", {31'd0, tx_ready}, 32'd0);
    tick();
    chk("rdy_after_clk", {31'd0, tx_ready}, 32'd1);

    // single byte 0xA5, loopback
    loopback = 1'b1;
    rises.delete(); ssel_rises.delete();
    rv0 = rv_cnt;
    send(8'hA5, 1'b1, a);
    chk("ssel_low", {31'd0, SSEL}, 32'd0);
    chk("mosi_bit7", {31'd0, MOSI}, 32'd1);
    chk("busy_high", {31'd0, busy}, 32'd1);
    wait_rv(rv0 + 1);
    chk("a5_rxdata", {24'd0, rx_data}, 32'hA5);
    chk("a5_rv_time", rv_cyc - a, 16 * D);
    chk("a5_slave_saw", {24'd0, sl_rx}, 32'hA5);
    chk("a5_nrises", rises.size(), 8);
    for (int k = 0; k < 8 && k < rises.size(); k++)
      chk("a5_rise_time", rises[k] - a, D * (2 * k + 1));
    chk("a5_ssel_rise_n", ssel_rises.size(), 1);
    if (ssel_rises.size() > 0) chk("a5_ssel_rise_t", ssel_rises[0] - a, 16 * D);
    chk("gap_not_ready", {31'd0, tx_ready}, 32'd0);
    wait_ready(t_rdy);
    chk("a5_ready_time", t_rdy - a, 17 * D);
    chk("idle_mosi", {31'd0, MOSI}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // slave model returning 0x3C, then randomized pairs
    loopback = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin b = 8'h05; s = 8'h3C; end
      else begin b = 8'($urandom); s = 8'($urandom); end
      sl_tx = s;
      rv0 = rv_cnt;
      send(b, 1'b1, a);
      wait_rv(rv0 + 1);
      chk("sl_rxdata", {24'd0, rx_data}, {24'd0, s});
      chk("sl_received", {24'd0, sl_rx}, {24'd0, b});
      chk("sl_rv_time", rv_cyc - a, 16 * D);
    end

    // burst of two random bytes, loopback
    loopback = 1'b1;
    wait_ready(t_rdy);
    tick();
    rises.delete(); ssel_rises.delete();
    b = 8'($urandom); s = 8'($urandom);
    rv0 = rv_cnt;
    send(b, 1'b0, a);
    wait_rv(rv0 + 1);
    chk("burst_rx0", {24'd0, rx_data}, {24'd0, b});
    chk("burst_hold_ssel", {31'd0, SSEL}, 32'd0);
    send(s, 1'b1, a2);
    chk("burst_b2b", a2 - a, 16 * D + 1);
    wait_rv(rv0 + 2);
    chk("burst_rx1", {24'd0, rx_data}, {24'd0, s});
    chk("burst_nrises", rises.size(), 16);
    chk("burst_ssel_rise_n", ssel_rises.size(), 1);
    if (ssel_rises.size() > 0) chk("burst_ssel_rise_t", ssel_rises[0] - a2, 16 * D);

    // tx_valid during an active byte is ignored until GAP ends
    wait_ready(t_rdy);
    rises.delete();
    rv0 = rv_cnt;
    send(8'h00, 1'b1, a);
    wait_rises(1);
    tx_data = 8'hFF; tx_last = 1'b1; tx_valid = 1'b1;
    wait_rv(rv0 + 1);
    chk("ign_rx", {24'd0, rx_data}, 32'h00);
    chk("ign_slave", {24'd0, sl_rx}, 32'h00);
    wait_ready(t_rdy);
    a2 = cyc + 1;
    tick();
    tx_valid = 1'b0;
    chk("ign_accept_t", a2 - a, 17 * D + 1);
    wait_rv(rv0 + 2);
    chk("ign_ff_rx", {24'd0, rx_data}, 32'hFF);

    // reset in the middle of a byte
    wait_ready(t_rdy);
    rises.delete();
    send(8'h81, 1'b1, a);
    wait_rises(3);
    rv0 = rv_cnt;
    rst_n = 1'b0;
    #1;
    chk("mr_sck", {31'd0, SCK}, 32'd0);
    chk("mr_ssel", {31'd0, SSEL}, 32'd1);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_ready", {31'd0, tx_ready}, 32'd0);
    chk("mr_rxdata", {24'd0, rx_data}, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20 * D) tick();
    chk("mr_no_rv", rv_cnt, rv0);
    send(8'h81, 1'b1, a);
    wait_rv(rv0 + 1);
    chk("mr_after_rx", {24'd0, rx_data}, 32'h81);
    chk("mr_after_slave", {24'd0, sl_rx}, 32'h81);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
